fetch_stage: RTL and testbench

Instruction fetch stage for the 16-bit, 2-bit-opcode single-issue CPU. It owns the program counter and runs a req/ack handshake with instruction memory. It registers each fetched word and presents it, split into fields, to the control unit and register file downstream; `opcode` feeds the control unit directly. A one-entry skid buffer absorbs a word that returns while downstream is stalled.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/fetch_skid_buffer.sv | 61 ++++++
 rtl/fetch_stage.sv | 141 ++++++++++++++
 tb/tb_fetch_stage.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit, 2-bit-opcode single-issue CPU.
// Holds the instruction width, opcode encodings, instruction field bit
// positions and the fetch-stage state encoding.
package cpu_pkg;

  localparam int INSTR_WIDTH = 16;

  localparam logic [1:0] OP_RTYPE = 2'b00;
  localparam logic [1:0] OP_ADDI  = 2'b01;
  localparam logic [1:0] OP_LW    = 2'b10;
  localparam logic [1:0] OP_SW    = 2'b11;

  // Instruction field layout: [15:14] opcode, [13:12] rs, [11:10] rt,
  // [9:8] rd, [7:0] imm.
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 14;
  localparam int RS_MSB  = 13;
  localparam int RS_LSB  = 12;
  localparam int RT_MSB  = 11;
  localparam int RT_LSB  = 10;
  localparam int RD_MSB  = 9;
  localparam int RD_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Purpose: one-entry holding slot for an instruction word plus its PC.
// Latency: load is visible (full=1) the cycle after the load edge.
// Backpressure: none of its own; the parent only loads it when empty.
// Ports:
//   clk, rst            clock, async active-high reset
//   load, load_instr,   capture an instruction and its PC
//   load_pc
//   unload              release the held entry
//   full, instr, pc     occupancy flag and held contents
module fetch_skid_buffer
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [INSTR_WIDTH-1:0] load_instr,
  input  logic [ADDR_WIDTH-1:0]  load_pc,
  input  logic                   unload,
  output logic                   full,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  pc
);

  logic                   full_q, full_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;

  // Load and unload are mutually exclusive in practice (load only while
  // fetching, unload only while draining); load wins if both ever occur.
  always_comb begin
    full_d  = full_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (load) begin
      full_d  = 1'b1;
      instr_d = load_instr;
      pc_d    = load_pc;
    end else if (unload) begin
      full_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      full_q  <= full_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign full  = full_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Purpose: instruction fetch; owns the PC, runs req/ack with imem, presents
//          registered instruction fields downstream.
// Latency: imem_req one cycle after Enable; instr_valid the cycle after ack.
// Backpressure: stall holds the output word; one late word goes to the skid
//               buffer and no new request issues until it drains.
// Ports:
//   Clock, Reset, Enable        clock, async active-high reset, fetch enable
//   imem_req/addr/ack/rdata     instruction memory handshake
//   stall                       downstream cannot take the presented word
//   instr_valid, instr, opcode, rs, rt, rd, imm, pc_out   presented word
// RESET_PC must be even.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Enable,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   stall,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [1:0]             opcode,
  output logic [1:0]             rs,
  output logic [1:0]             rt,
  output logic [1:0]             rd,
  output logic [7:0]             imm,
  output logic [ADDR_WIDTH-1:0]  pc_out
);

  fetch_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic                   req_q, req_d;
  logic                   out_vld_q, out_vld_d;
  logic [INSTR_WIDTH-1:0] out_instr_q, out_instr_d;
  logic [ADDR_WIDTH-1:0]  out_pc_q, out_pc_d;

  logic                   consume, ack_fire, to_out, to_skid, drain_move;
  logic                   skid_full;
  logic [INSTR_WIDTH-1:0] skid_instr;
  logic [ADDR_WIDTH-1:0]  skid_pc;

  always_comb begin
    // stall only matters while something is being presented
    consume    = out_vld_q & ~stall;
    // acks outside FETCH (e.g. a late ack after Reset) are ignored
    ack_fire   = (state_q == FS_FETCH) & imem_ack;
    to_out     = ack_fire & (~out_vld_q | consume);
    to_skid    = ack_fire & out_vld_q & ~consume;
    drain_move = skid_full & consume;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      FS_IDLE: begin
        if (Enable && !skid_full) state_d = FS_FETCH;
      end
      FS_FETCH: begin
        // Request is held until acked, regardless of Enable.
        if (ack_fire) begin
          pc_d = pc_q + ADDR_WIDTH'(2);
          if (to_skid)      state_d = FS_DRAIN;
          else if (!Enable) state_d = FS_IDLE;
        end
      end
      FS_DRAIN: begin
        if (drain_move) state_d = Enable ? FS_FETCH : FS_IDLE;
      end
      default: state_d = FS_IDLE;
    endcase
    req_d = (state_d == FS_FETCH);
  end

  always_comb begin
    out_vld_d   = out_vld_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    if (to_out) begin
      out_vld_d   = 1'b1;
      out_instr_d = imem_rdata;
      out_pc_d    = pc_q;
    end else if (drain_move) begin
      out_vld_d   = 1'b1;
      out_instr_d = skid_instr;
      out_pc_d    = skid_pc;
    end else if (consume) begin
      out_vld_d   = 1'b0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= FS_IDLE;
      pc_q        <= RESET_PC;
      req_q       <= 1'b0;
      out_vld_q   <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_q       <= req_d;
      out_vld_q   <= out_vld_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

  fetch_skid_buffer #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_skid (
    .clk        (Clock),
    .rst        (Reset),
    .load       (to_skid),
    .load_instr (imem_rdata),
    .load_pc    (pc_q),
    .unload     (drain_move),
    .full       (skid_full),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = out_vld_q;
  assign instr       = out_instr_q;
  assign opcode      = out_instr_q[OP_MSB:OP_LSB];
  assign rs          = out_instr_q[RS_MSB:RS_LSB];
  assign rt          = out_instr_q[RT_MSB:RT_LSB];
  assign rd          = out_instr_q[RD_MSB:RD_LSB];
  assign imm         = out_instr_q[IMM_MSB:IMM_LSB];
  assign pc_out      = out_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: dut0 uses RESET_PC=0, dut1 uses
// RESET_PC=0xFC to exercise PC wrap.
module tb_fetch_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, ack, stall;
  logic [15:0] rdata;
  logic        req, vld;
  logic [7:0]  addr, pcout, imm;
  logic [15:0] ins;
  logic [1:0]  op, rs, rt, rd;

  logic        en1, ack1, stall1;
  logic [15:0] rdata1;
  logic        req1, vld1;
  logic [7:0]  addr1, pcout1, imm1;
  logic [15:0] ins1;
  logic [1:0]  op1, rs1, rt1, rd1;

  int checks = 0;
  int failures = 0;

  fetch_stage #(.ADDR_WIDTH(8), .RESET_PC(8'h00)) dut0 (
    .Clock(clk), .Reset(rst), .Enable(en),
    .imem_req(req), .imem_addr(addr), .imem_ack(ack), .imem_rdata(rdata),
    .stall(stall), .instr_valid(vld), .instr(ins), .opcode(op),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm), .pc_out(pcout)
  );

  fetch_stage #(.ADDR_WIDTH(8), .RESET_PC(8'hFC)) dut1 (
    .Clock(clk), .Reset(rst), .Enable(en1),
    .imem_req(req1), .imem_addr(addr1), .imem_ack(ack1), .imem_rdata(rdata1),
    .stall(stall1), .instr_valid(vld1), .instr(ins1), .opcode(op1),
    .rs(rs1), .rt(rt1), .rd(rd1), .imm(imm1), .pc_out(pcout1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] zw_word [4];
  logic [1:0]  zw_op   [4];
  logic [5:0]  zw_regs [4];
  logic [7:0]  zw_imm  [4];
  logic [7:0]  wrap_addr [4];
  logic [15:0] wrap_word [4];

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    zw_word   = '{16'h1234, 16'h5A01, 16'h8C02, 16'hC003};
    zw_op     = '{OP_RTYPE, OP_ADDI, OP_LW, OP_SW};
    zw_regs   = '{6'b01_00_10, 6'b01_10_10, 6'b00_11_00, 6'b00_00_00};
    zw_imm    = '{8'h34, 8'h01, 8'h02, 8'h03};
    wrap_addr = '{8'hFC, 8'hFE, 8'h00, 8'h02};
    wrap_word = '{16'h0111, 16'h4222, 16'h8333, 16'hC444};

    rst = 1'b1; en = 1'b0; ack = 1'b0; stall = 1'b0; rdata = '0;
    en1 = 1'b0; ack1 = 1'b0; stall1 = 1'b0; rdata1 = '0;
    tick(); tick();

    // reset values
    chk("rst_req", req, 0);
    chk("rst_addr", addr, 8'h00);
    chk("rst_vld", vld, 0);
    chk("rst_instr", ins, 0);
    chk("rst_fields", {op, rs, rt, rd, imm}, 0);
    chk("rst_pc_out", pcout, 8'h00);
    chk("rst_addr1", addr1, 8'hFC);
    chk("rst_pc_out1", pcout1, 8'hFC);

    // Enable held low: nothing happens
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("idle_req", req, 0);
      chk("idle_vld", vld, 0);
      chk("idle_instr", ins, 0);
    end

    // zero-wait memory: four back-to-back words
    en = 1'b1;
    tick();
    chk("zw_req0", req, 1);
    chk("zw_addr0", addr, 8'h00);
    for (int i = 0; i < 4; i++) begin
      rdata = zw_word[i];
      ack = 1'b1;
      if (i == 3) en = 1'b0;
      tick();
      chk("zw_vld", vld, 1);
      chk("zw_instr", ins, zw_word[i]);
      chk("zw_pc_out", pcout, 8'(2 * i));
      chk("zw_opcode", op, zw_op[i]);
      chk("zw_rs_rt_rd", {rs, rt, rd}, zw_regs[i]);
      chk("zw_imm", imm, zw_imm[i]);
      chk("zw_req", req, (i < 3) ? 1 : 0);
    end
    ack = 1'b0;
    tick();
    chk("zw_done_vld", vld, 0);
    chk("zw_done_req", req, 0);
    chk("zw_done_addr", addr, 8'h08);

    // ack delayed by 3 cycles
    en = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("dly_req", req, 1);
      chk("dly_addr", addr, 8'h08);
      chk("dly_vld", vld, 0);
      tick();
    end
    chk("dly_req_last", req, 1);
    chk("dly_addr_last", addr, 8'h08);
    rdata = 16'h4567; ack = 1'b1; en = 1'b0;
    tick();
    chk("dly_vld", vld, 1);
    chk("dly_instr", ins, 16'h4567);
    chk("dly_pc_out", pcout, 8'h08);
    chk("dly_req_off", req, 0);
    chk("dly_pc_adv", addr, 8'h0A);
    ack = 1'b0;
    tick();
    chk("dly_vld_off", vld, 0);

    // stall with a request outstanding, word lands in the skid buffer
    en = 1'b1;
    tick();
    rdata = 16'h9111; ack = 1'b1;
    tick();
    chk("stl_first", ins, 16'h9111);
    stall = 1'b1; ack = 1'b0;
    tick();
    chk("stl_req_held", req, 1);
    chk("stl_addr_held", addr, 8'h0C);
    rdata = 16'h6222; ack = 1'b1;
    tick();
    ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("stl_no_req", req, 0);
      chk("stl_vld", vld, 1);
      chk("stl_instr", ins, 16'h9111);
      chk("stl_pc_out", pcout, 8'h0A);
      if (k < 3) tick();
    end
    stall = 1'b0; en = 1'b0;
    tick();
    chk("stl_rel_vld", vld, 1);
    chk("stl_rel_instr", ins, 16'h6222);
    chk("stl_rel_pc_out", pcout, 8'h0C);
    chk("stl_rel_req", req, 0);
    chk("stl_rel_addr", addr, 8'h0E);
    tick();
    chk("stl_empty", vld, 0);

    // PC wrap on the RESET_PC=0xFC instance
    en1 = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("wrap_req", req1, 1);
      chk("wrap_addr", addr1, wrap_addr[i]);
      rdata1 = wrap_word[i];
      ack1 = 1'b1;
      if (i == 3) en1 = 1'b0;
      tick();
      chk("wrap_vld", vld1, 1);
      chk("wrap_pc_out", pcout1, wrap_addr[i]);
      chk("wrap_instr", ins1, wrap_word[i]);
    end
    ack1 = 1'b0;
    tick();

    // Reset while a request waits for ack
    en = 1'b1;
    tick();
    rdata = 16'h3333; ack = 1'b1;
    tick();
    ack = 1'b0; stall = 1'b1;
    tick();
    chk("rmid_pre_vld", vld, 1);
    chk("rmid_pre_req", req, 1);
    chk("rmid_pre_addr", addr, 8'h10);
    rst = 1'b1;
    #1;
    chk("rmid_req", req, 0);
    chk("rmid_vld", vld, 0);
    chk("rmid_instr", ins, 0);
    chk("rmid_addr", addr, 8'h00);
    chk("rmid_pc_out", pcout, 8'h00);
    en = 1'b0; stall = 1'b0; ack = 1'b1; rdata = 16'hFFFF;
    tick();
    chk("rmid_late_vld", vld, 0);
    rst = 1'b0;
    tick();
    chk("rmid_post_vld", vld, 0);
    chk("rmid_post_instr", ins, 0);
    chk("rmid_post_req", req, 0);
    ack = 1'b0; en = 1'b1;
    tick();
    chk("rmid_restart_req", req, 1);
    chk("rmid_restart_addr", addr, 8'h00);
    rdata = 16'h7777; ack = 1'b1; en = 1'b0;
    tick();
    chk("rmid_restart_vld", vld, 1);
    chk("rmid_restart_instr", ins, 16'h7777);
    chk("rmid_restart_pc_out", pcout, 8'h00);
    chk("rmid_restart_pc_adv", addr, 8'h02);
    ack = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
